control_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer that drives the control inputs of the SPARC-subset datapath (`DataPathV4`-style: IR, MAR, MDR, PC, nPC, PSR, register file, ALU, `ram_256b`). It replaces the hand-toggled testbench stimulus with a state machine. The machine sequences instruction fetch through MAR/MDR/IR, executes ALU, load/store and Bicc instructions, and advances PC/nPC with SPARC delayed-branch semantics. It sits beside the datapath, sees only `IR`, `MFC` and the ALU flags, and owns every enable and mux select.

---
 rtl/control_sequencer_if.sv | 56 +++++
 rtl/control_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the fetch/decode/execute sequencer and the
// SPARC-subset datapath. The sequencer side (master) sees IR, MFC and the ALU
// flags and owns every load enable, mux select and adder control; the
// datapath side (slave) sees the mirror image.
//
// Memory handshake (MFA/MFC): in a memory state the sequencer raises MFA
// with MOP_SEL/OP1 stable and keeps them stable until it samples MFC = 1 on
// a rising edge. The access completes on that edge, and MFA falls in the
// following state. MFC arriving while MFA is low carries no meaning and is
// ignored.
interface control_sequencer_if;
   logic [31:0] IR;
   logic        MFC;
   logic        N;
   logic        Z;

   logic        IRE;
   logic        MDRE;
   logic        MARE;
   logic        PCE;
   logic        nPCE;
   logic        RFE;
   logic        PSRE;
   logic        ALUE;
   logic        MFA;
   logic        MOP_SEL;
   logic        AOP_SEL;
   logic        RA_SEL;
   logic [5:0]  OP1;
   logic [1:0]  MAR_SEL;
   logic [1:0]  MDR_SEL;
   logic [1:0]  nPC_SEL;
   logic [1:0]  ALU_SEL;
   logic [1:0]  CIN_SEL;
   logic [1:0]  RC_SEL;
   logic        nPC_ADD;
   logic        nPC_ADDSEL;
   logic        BAUX;
   logic        DISP_SEL;

   modport master (
      input  IR, MFC, N, Z,
      output IRE, MDRE, MARE, PCE, nPCE, RFE, PSRE,
      output ALUE, MFA, MOP_SEL, AOP_SEL, RA_SEL, OP1,
      output MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL,
      output nPC_ADD, nPC_ADDSEL, BAUX, DISP_SEL
   );

   modport slave (
      output IR, MFC, N, Z,
      input  IRE, MDRE, MARE, PCE, nPCE, RFE, PSRE,
      input  ALUE, MFA, MOP_SEL, AOP_SEL, RA_SEL, OP1,
      input  MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL,
      input  nPC_ADD, nPC_ADDSEL, BAUX, DISP_SEL
   );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the SPARC-subset datapath.
// Fetches through MAR/MDR/IR, executes ALU, ld/st and Bicc instructions and
// advances PC/nPC with delayed-branch semantics (PC <- nPC every instruction,
// nPC <- nPC+4 or PC+4*disp22).
// All datapath controls are Moore outputs decoded from registered state; the
// only IR fields needed after DEC (i bit, cc bit, taken) are latched in DEC.
// TO_W must be wide enough that 2**TO_W > MFC_TIMEOUT.
module control_sequencer #(
   parameter int MFC_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   control_sequencer_if.master dp,
   output logic                halted,
   output logic [1:0]          err_code,
   output logic [3:0]          state_dbg
);

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_F_MAR  = 4'd1,
      S_F_MEM  = 4'd2,
      S_F_MDR  = 4'd3,
      S_F_IR   = 4'd4,
      S_DEC    = 4'd5,
      S_EXE    = 4'd6,
      S_M_ADDR = 4'd7,
      S_M_STD  = 4'd8,
      S_M_ST   = 4'd9,
      S_M_LD   = 4'd10,
      S_L_MDR  = 4'd11,
      S_L_WB   = 4'd12,
      S_PC_UPD = 4'd13,
      S_HALT   = 4'd14
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_WRITE = 6'h04;
   localparam logic [5:0] OP_READ  = 6'h08;

   state_t state, state_nxt;

   // Flags latched in DEC and consumed by later states of the instruction
   logic            taken, taken_nxt;
   logic            is_store, is_store_nxt;
   logic            imm_q, imm_nxt;
   logic            cc_q, cc_nxt;
   logic [1:0]      err_q, err_nxt;
   logic [TO_W-1:0] to_cnt;

   // Instruction fields
   logic [1:0] op;
   logic [2:0] op2;
   logic [3:0] cond;
   logic [5:0] op3;
   logic       alu_op_ok;
   logic       mem_state;
   logic       to_expire;

   // Local copies of the datapath controls
   logic       ire, mdre, mare, pce, npce, rfe, psre;
   logic       alue, mfa, mop_sel, aop_sel, ra_sel;
   logic [5:0] op1;
   logic [1:0] mar_sel, mdr_sel, npc_sel, alu_sel, cin_sel, rc_sel;
   logic       npc_add, npc_addsel, baux, disp_sel;

   // IR bits never looked at by the sequencer (rd, rs1/rs2, simm13, disp22)
   logic unused_ok;
   assign unused_ok = &{1'b0, dp.N, dp.IR[29], dp.IR[18:14], dp.IR[12:0]};

   assign op   = dp.IR[31:30];
   assign op2  = dp.IR[24:22];
   assign cond = dp.IR[28:25];
   assign op3  = dp.IR[24:19];

   // Format-3 arithmetic opcodes the datapath ALU implements
   always_comb begin
      alu_op_ok = 1'b0;
      case (op3)
         6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
         6'h10, 6'h11, 6'h12, 6'h13, 6'h14: alu_op_ok = 1'b1;
         default:                           alu_op_ok = 1'b0;
      endcase
   end

   assign mem_state = (state == S_F_MEM) || (state == S_M_ST) || (state == S_M_LD);

   // Expire on the cycle that would make the MFC_TIMEOUT-th unanswered MFA
   // cycle; an MFC on that same cycle still completes the access.
   assign to_expire = !dp.MFC && ((to_cnt + TO_W'(1)) == TO_W'(MFC_TIMEOUT));

   // State, decode flags and error code register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= S_RST;
         taken    <= 1'b0;
         is_store <= 1'b0;
         imm_q    <= 1'b0;
         cc_q     <= 1'b0;
         err_q    <= ERR_NONE;
      end else begin
         state    <= state_nxt;
         taken    <= taken_nxt;
         is_store <= is_store_nxt;
         imm_q    <= imm_nxt;
         cc_q     <= cc_nxt;
         err_q    <= err_nxt;
      end
   end

   // Memory timeout counter: zero outside memory states, counts unanswered MFA cycles
   always_ff @(posedge Clk) begin
      if (Reset || !mem_state) begin
         to_cnt <= '0;
      end else if (!dp.MFC) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Next-state and decode logic
   always_comb begin
      state_nxt    = state;
      taken_nxt    = taken;
      is_store_nxt = is_store;
      imm_nxt      = imm_q;
      cc_nxt       = cc_q;
      err_nxt      = err_q;
      unique case (state)
         S_RST: begin
            taken_nxt = 1'b0;
            err_nxt   = ERR_NONE;
            state_nxt = S_F_MAR;
         end
         S_F_MAR: state_nxt = S_F_MEM;
         S_F_MEM: begin
            if (dp.MFC) begin
               state_nxt = S_F_MDR;
            end else if (to_expire) begin
               state_nxt = S_HALT;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         S_F_MDR: state_nxt = S_F_IR;
         S_F_IR:  state_nxt = S_DEC;
         S_DEC: begin
            imm_nxt   = dp.IR[13];
            cc_nxt    = dp.IR[23];
            state_nxt = S_HALT;
            err_nxt   = ERR_ILLEGAL;
            case (op)
               2'b10: begin
                  if (alu_op_ok) begin
                     state_nxt = S_EXE;
                     err_nxt   = err_q;
                  end
               end
               2'b11: begin
                  if (op3 == 6'h00) begin
                     state_nxt    = S_M_ADDR;
                     is_store_nxt = 1'b0;
                     err_nxt      = err_q;
                  end else if (op3 == 6'h04) begin
                     state_nxt    = S_M_ADDR;
                     is_store_nxt = 1'b1;
                     err_nxt      = err_q;
                  end
               end
               2'b00: begin
                  if (op2 == 3'b010) begin
                     case (cond)
                        4'b1000: begin
                           taken_nxt = 1'b1;
                           state_nxt = S_PC_UPD;
                           err_nxt   = err_q;
                        end
                        4'b0000: begin
                           taken_nxt = 1'b0;
                           state_nxt = S_PC_UPD;
                           err_nxt   = err_q;
                        end
                        4'b0001: begin
                           taken_nxt = dp.Z;
                           state_nxt = S_PC_UPD;
                           err_nxt   = err_q;
                        end
                        4'b1001: begin
                           taken_nxt = !dp.Z;
                           state_nxt = S_PC_UPD;
                           err_nxt   = err_q;
                        end
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
         S_EXE:    state_nxt = S_PC_UPD;
         S_M_ADDR: state_nxt = is_store ? S_M_STD : S_M_LD;
         S_M_STD:  state_nxt = S_M_ST;
         S_M_ST: begin
            if (dp.MFC) begin
               state_nxt = S_PC_UPD;
            end else if (to_expire) begin
               state_nxt = S_HALT;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         S_M_LD: begin
            if (dp.MFC) begin
               state_nxt = S_L_MDR;
            end else if (to_expire) begin
               state_nxt = S_HALT;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         S_L_MDR: state_nxt = S_L_WB;
         S_L_WB:  state_nxt = S_PC_UPD;
         S_PC_UPD: begin
            taken_nxt = 1'b0;
            state_nxt = S_F_MAR;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_HALT;
      endcase
   end

   // Moore control outputs decoded from the current state
   always_comb begin
      ire        = 1'b1;
      mdre       = 1'b1;
      mare       = 1'b1;
      pce        = 1'b1;
      npce       = 1'b1;
      rfe        = 1'b1;
      psre       = 1'b1;
      alue       = 1'b0;
      mfa        = 1'b0;
      mop_sel    = 1'b0;
      aop_sel    = 1'b0;
      ra_sel     = 1'b0;
      op1        = 6'h00;
      mar_sel    = 2'd0;
      mdr_sel    = 2'd0;
      npc_sel    = 2'd0;
      alu_sel    = 2'd0;
      cin_sel    = 2'd0;
      rc_sel     = 2'd0;
      npc_add    = 1'b1;
      npc_addsel = 1'b0;
      baux       = 1'b1;
      disp_sel   = 1'b0;
      unique case (state)
         S_F_MAR: begin
            mar_sel = 2'd1;
            mare    = 1'b0;
         end
         S_F_MEM, S_M_LD: begin
            mop_sel = 1'b1;
            op1     = OP_READ;
            mfa     = 1'b1;
         end
         S_F_MDR, S_L_MDR: begin
            mdr_sel = 2'd0;
            mdre    = 1'b0;
         end
         S_F_IR: ire = 1'b0;
         S_EXE: begin
            ra_sel  = 1'b0;
            alu_sel = {1'b0, imm_q};
            aop_sel = 1'b0;
            alue    = 1'b1;
            rc_sel  = 2'd0;
            cin_sel = 2'd2;
            rfe     = 1'b0;
            psre    = !cc_q;
         end
         S_M_ADDR: begin
            ra_sel  = 1'b0;
            alu_sel = {1'b0, imm_q};
            aop_sel = 1'b1;
            op1     = OP_ADD;
            alue    = 1'b1;
            mar_sel = 2'd0;
            mare    = 1'b0;
         end
         S_M_STD: begin
            ra_sel  = 1'b1;
            mdr_sel = 2'd1;
            mdre    = 1'b0;
         end
         S_M_ST: begin
            mop_sel = 1'b1;
            op1     = OP_WRITE;
            mfa     = 1'b1;
         end
         S_L_WB: begin
            rc_sel  = 2'd0;
            cin_sel = 2'd3;
            rfe     = 1'b0;
         end
         S_PC_UPD: begin
            pce     = 1'b0;
            npce    = 1'b0;
            npc_sel = taken ? 2'd2 : 2'd0;
         end
         default: ;
      endcase
   end

   assign dp.IRE        = ire;
   assign dp.MDRE       = mdre;
   assign dp.MARE       = mare;
   assign dp.PCE        = pce;
   assign dp.nPCE       = npce;
   assign dp.RFE        = rfe;
   assign dp.PSRE       = psre;
   assign dp.ALUE       = alue;
   assign dp.MFA        = mfa;
   assign dp.MOP_SEL    = mop_sel;
   assign dp.AOP_SEL    = aop_sel;
   assign dp.RA_SEL     = ra_sel;
   assign dp.OP1        = op1;
   assign dp.MAR_SEL    = mar_sel;
   assign dp.MDR_SEL    = mdr_sel;
   assign dp.nPC_SEL    = npc_sel;
   assign dp.ALU_SEL    = alu_sel;
   assign dp.CIN_SEL    = cin_sel;
   assign dp.RC_SEL     = rc_sel;
   assign dp.nPC_ADD    = npc_add;
   assign dp.nPC_ADDSEL = npc_addsel;
   assign dp.BAUX       = baux;
   assign dp.DISP_SEL   = disp_sel;

   assign halted    = (state == S_HALT);
   assign err_code  = err_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: state traces, per-state control
// values, cycle counts, Bicc decisions, illegal/timeout halts and reset in
// the middle of a memory access.
module tb_control_sequencer;

   localparam logic [3:0] S_RST    = 4'd0;
   localparam logic [3:0] S_F_MAR  = 4'd1;
   localparam logic [3:0] S_F_MEM  = 4'd2;
   localparam logic [3:0] S_F_MDR  = 4'd3;
   localparam logic [3:0] S_F_IR   = 4'd4;
   localparam logic [3:0] S_DEC    = 4'd5;
   localparam logic [3:0] S_EXE    = 4'd6;
   localparam logic [3:0] S_M_ADDR = 4'd7;
   localparam logic [3:0] S_M_STD  = 4'd8;
   localparam logic [3:0] S_M_ST   = 4'd9;
   localparam logic [3:0] S_M_LD   = 4'd10;
   localparam logic [3:0] S_L_MDR  = 4'd11;
   localparam logic [3:0] S_L_WB   = 4'd12;
   localparam logic [3:0] S_PC_UPD = 4'd13;
   localparam logic [3:0] S_HALT   = 4'd14;

   // enables(7) ALUE MFA MOP AOP RA OP1(6) selects(12) nPC_ADD ADDSEL BAUX DISP halted err(2)
   localparam logic [36:0] RESET_VEC = {7'h7F, 1'b0, 1'b0, 3'b000, 6'h00, 12'h000,
                                        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};

   logic       Clk;
   logic       Reset;
   logic       halted;
   logic [1:0] err_code;
   logic [3:0] state_dbg;

   control_sequencer_if dp_if ();

   control_sequencer #(.MFC_TIMEOUT(15), .TO_W(4)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .dp       (dp_if),
      .halted   (halted),
      .err_code (err_code),
      .state_dbg(state_dbg)
   );

   logic [36:0] out_vec;
   assign out_vec = {dp_if.IRE, dp_if.MDRE, dp_if.MARE, dp_if.PCE, dp_if.nPCE, dp_if.RFE, dp_if.PSRE,
                     dp_if.ALUE, dp_if.MFA, dp_if.MOP_SEL, dp_if.AOP_SEL, dp_if.RA_SEL, dp_if.OP1,
                     dp_if.MAR_SEL, dp_if.MDR_SEL, dp_if.nPC_SEL, dp_if.ALU_SEL, dp_if.CIN_SEL,
                     dp_if.RC_SEL, dp_if.nPC_ADD, dp_if.nPC_ADDSEL, dp_if.BAUX, dp_if.DISP_SEL,
                     halted, err_code};

   int n_pass  = 0;
   int n_total = 0;

   // Memory model: answers MFA with MFC on the (delay+1)-th MFA cycle; -1 never answers
   int fetch_delay = 0;
   int data_delay  = 0;
   int mfa_cnt     = 0;

   // Clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Memory responder
   initial begin
      dp_if.MFC = 1'b0;
      forever begin
         @(negedge Clk);
         if (dp_if.MFA === 1'b1) begin
            if (state_dbg == S_F_MEM) dp_if.MFC = (mfa_cnt == fetch_delay);
            else                      dp_if.MFC = (mfa_cnt == data_delay);
            mfa_cnt++;
         end else begin
            dp_if.MFC = 1'b0;
            mfa_cnt   = 0;
         end
      end
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      Reset = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, output int steps, output bit found);
      found = 1'b0;
      steps = 0;
      while (!found && steps < budget) begin
         @(negedge Clk);
         steps++;
         if (state_dbg == s) found = 1'b1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      dp_if.IR = 32'h9C044012;
      Reset = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      n_total++;
      if (state_dbg !== S_RST) $display("FAIL reset_state: got %0d want %0d", state_dbg, S_RST);
      else n_pass++;
      n_total++;
      if (out_vec !== RESET_VEC) $display("FAIL reset_outputs: got %h want %h", out_vec, RESET_VEC);
      else n_pass++;
      Reset = 1'b0;
      @(negedge Clk);
      n_total++;
      if (state_dbg !== S_F_MAR) $display("FAIL reset_exit: got %0d want %0d", state_dbg, S_F_MAR);
      else n_pass++;
   endtask

   task automatic test_alu();
      logic [3:0] exp_trace [8];
      exp_trace = '{S_F_MAR, S_F_MEM, S_F_MDR, S_F_IR, S_DEC, S_EXE, S_PC_UPD, S_F_MAR};
      dp_if.IR = 32'h9C044012;
      fetch_delay = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         n_total++;
         if (state_dbg !== exp_trace[i])
            $display("FAIL alu_trace[%0d]: got %0d want %0d", i, state_dbg, exp_trace[i]);
         else n_pass++;
         if (exp_trace[i] == S_EXE) begin
            n_total++;
            if ({dp_if.RFE, dp_if.CIN_SEL, dp_if.PSRE, dp_if.ALUE, dp_if.ALU_SEL, dp_if.AOP_SEL} !==
                {1'b0, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0})
               $display("FAIL alu_exe_ctl: RFE=%b CIN=%0d PSRE=%b ALUE=%b ALU_SEL=%0d want 0,2,1,1,0",
                        dp_if.RFE, dp_if.CIN_SEL, dp_if.PSRE, dp_if.ALUE, dp_if.ALU_SEL);
            else n_pass++;
         end
         if (exp_trace[i] == S_PC_UPD) begin
            n_total++;
            if ({dp_if.PCE, dp_if.nPCE, dp_if.nPC_SEL} !== {1'b0, 1'b0, 2'd0})
               $display("FAIL alu_pc_upd: PCE=%b nPCE=%b nPC_SEL=%0d want 0,0,0",
                        dp_if.PCE, dp_if.nPCE, dp_if.nPC_SEL);
            else n_pass++;
         end
      end
   endtask

   task automatic test_alu_cc();
      int  st;
      bit  ok;
      dp_if.IR = 32'h9C846012;   // addcc with immediate
      do_reset();
      wait_state(S_EXE, 20, st, ok);
      n_total++;
      if (!ok || st != 6) $display("FAIL alucc_reach_exe: found=%0d steps=%0d want 1,6", ok, st);
      else n_pass++;
      n_total++;
      if ({dp_if.PSRE, dp_if.ALU_SEL, dp_if.RFE} !== {1'b0, 2'd1, 1'b0})
         $display("FAIL alucc_exe_ctl: PSRE=%b ALU_SEL=%0d RFE=%b want 0,1,0",
                  dp_if.PSRE, dp_if.ALU_SEL, dp_if.RFE);
      else n_pass++;
   endtask

   task automatic test_load();
      int  st, cyc, mfa_ld;
      bit  ok, done, addr_ok, wb_ok, saw_wb;
      dp_if.IR = 32'hC2006004;
      fetch_delay = 0;
      data_delay  = 3;
      do_reset();
      wait_state(S_F_MAR, 4, st, ok);
      cyc = 0; mfa_ld = 0; done = 0; addr_ok = 0; wb_ok = 0; saw_wb = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Clk);
         cyc++;
         if (state_dbg == S_M_LD && dp_if.MFA === 1'b1) mfa_ld++;
         if (state_dbg == S_M_ADDR)
            addr_ok = ({dp_if.ALU_SEL, dp_if.AOP_SEL, dp_if.OP1, dp_if.ALUE, dp_if.MARE, dp_if.MAR_SEL} ===
                       {2'd1, 1'b1, 6'h00, 1'b1, 1'b0, 2'd0});
         if (state_dbg == S_L_WB) begin
            saw_wb = 1;
            wb_ok  = ({dp_if.CIN_SEL, dp_if.RFE, dp_if.RC_SEL} === {2'd3, 1'b0, 2'd0});
         end
         if (state_dbg == S_F_MAR) done = 1;
      end
      n_total++;
      if (!ok || !done || cyc != 13) $display("FAIL load_cycles: done=%0d cycles=%0d want 1,13", done, cyc);
      else n_pass++;
      n_total++;
      if (mfa_ld != 4) $display("FAIL load_mfa_hold: got %0d want 4", mfa_ld);
      else n_pass++;
      n_total++;
      if (!addr_ok) $display("FAIL load_addr_ctl: got 0 want 1");
      else n_pass++;
      n_total++;
      if (!(saw_wb && wb_ok)) $display("FAIL load_wb_ctl: seen=%0d ok=%0d want 1,1", saw_wb, wb_ok);
      else n_pass++;
      data_delay = 0;
   endtask

   task automatic test_store();
      int  st, cyc;
      bit  ok, done, std_ok, st_ok;
      dp_if.IR = 32'hC2206004;
      fetch_delay = 0;
      data_delay  = 0;
      do_reset();
      wait_state(S_F_MAR, 4, st, ok);
      cyc = 0; done = 0; std_ok = 0; st_ok = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Clk);
         cyc++;
         if (state_dbg == S_M_STD)
            std_ok = ({dp_if.RA_SEL, dp_if.MDR_SEL, dp_if.MDRE} === {1'b1, 2'd1, 1'b0});
         if (state_dbg == S_M_ST)
            st_ok = ({dp_if.MOP_SEL, dp_if.OP1, dp_if.MFA} === {1'b1, 6'h04, 1'b1});
         if (state_dbg == S_F_MAR) done = 1;
      end
      n_total++;
      if (!ok || !done || cyc != 9) $display("FAIL store_cycles: done=%0d cycles=%0d want 1,9", done, cyc);
      else n_pass++;
      n_total++;
      if (!std_ok) $display("FAIL store_mdr_ctl: got 0 want 1");
      else n_pass++;
      n_total++;
      if (!st_ok) $display("FAIL store_write_ctl: got 0 want 1");
      else n_pass++;
   endtask

   task automatic test_branch();
      logic [31:0] br_ir  [6];
      logic        br_z   [6];
      logic [1:0]  br_sel [6];
      int          st;
      bit          ok;
      br_ir  = '{32'h02800004, 32'h12800004, 32'h10800004, 32'h00800004, 32'h02800004, 32'h12800004};
      br_z   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      br_sel = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};
      for (int k = 0; k < 6; k++) begin
         dp_if.IR = br_ir[k];
         dp_if.Z  = br_z[k];
         do_reset();
         wait_state(S_PC_UPD, 20, st, ok);
         n_total++;
         if (!ok || st != 6) $display("FAIL branch_cycles[%0d]: found=%0d steps=%0d want 1,6", k, ok, st);
         else n_pass++;
         n_total++;
         if (dp_if.nPC_SEL !== br_sel[k])
            $display("FAIL branch_npc_sel[%0d]: got %0d want %0d", k, dp_if.nPC_SEL, br_sel[k]);
         else n_pass++;
         n_total++;
         if ({dp_if.PCE, dp_if.nPCE} !== 2'b00)
            $display("FAIL branch_pc_en[%0d]: got %b want 00", k, {dp_if.PCE, dp_if.nPCE});
         else n_pass++;
      end
      dp_if.Z = 1'b0;
   endtask

   task automatic test_back_to_back();
      int  st;
      bit  ok;
      dp_if.IR = 32'h10800004;   // ba
      do_reset();
      wait_state(S_PC_UPD, 20, st, ok);
      n_total++;
      if (!ok || dp_if.nPC_SEL !== 2'd2) $display("FAIL b2b_first_taken: found=%0d nPC_SEL=%0d want 1,2", ok, dp_if.nPC_SEL);
      else n_pass++;
      dp_if.IR = 32'h9C044012;   // add follows the taken branch
      wait_state(S_PC_UPD, 20, st, ok);
      n_total++;
      if (!ok || st != 7) $display("FAIL b2b_second_cycles: found=%0d steps=%0d want 1,7", ok, st);
      else n_pass++;
      n_total++;
      if (dp_if.nPC_SEL !== 2'd0) $display("FAIL b2b_taken_cleared: got %0d want 0", dp_if.nPC_SEL);
      else n_pass++;
   endtask

   task automatic test_illegal();
      logic [31:0] bad_ir [4];
      int          st;
      bit          ok, hold_ok;
      bad_ir = '{32'h00000000, 32'h04800004, 32'h9C284012, 32'h40000000};
      for (int k = 0; k < 4; k++) begin
         dp_if.IR = bad_ir[k];
         do_reset();
         wait_state(S_HALT, 20, st, ok);
         n_total++;
         if (!ok || st != 6) $display("FAIL illegal_halt[%0d]: found=%0d steps=%0d want 1,6", k, ok, st);
         else n_pass++;
         n_total++;
         if ({halted, err_code} !== {1'b1, 2'd1})
            $display("FAIL illegal_err[%0d]: halted=%b err=%0d want 1,1", k, halted, err_code);
         else n_pass++;
         hold_ok = 1;
         for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (out_vec !== {RESET_VEC[36:3], 1'b1, 2'd1} || state_dbg !== S_HALT) hold_ok = 0;
         end
         n_total++;
         if (!hold_ok) $display("FAIL illegal_hold[%0d]: outputs moved during 20 halted cycles, want defaults", k);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int  cnt;
      bit  done;
      dp_if.IR = 32'h9C044012;
      fetch_delay = -1;
      do_reset();
      cnt = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Clk);
         if (dp_if.MFA === 1'b1) cnt++;
         if (state_dbg == S_HALT) done = 1;
      end
      n_total++;
      if (!done || cnt != 15) $display("FAIL timeout_mfa_cycles: halted=%0d mfa=%0d want 1,15", done, cnt);
      else n_pass++;
      n_total++;
      if ({halted, err_code, dp_if.MFA} !== {1'b1, 2'd2, 1'b0})
         $display("FAIL timeout_err: halted=%b err=%0d MFA=%b want 1,2,0", halted, err_code, dp_if.MFA);
      else n_pass++;
   endtask

   task automatic test_timeout_edge();
      int  cnt;
      bit  done;
      fetch_delay = 14;
      do_reset();
      cnt = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Clk);
         if (dp_if.MFA === 1'b1) cnt++;
         if (state_dbg == S_F_MDR || state_dbg == S_HALT) done = 1;
      end
      n_total++;
      if (!done || state_dbg !== S_F_MDR) $display("FAIL tedge_state: got %0d want %0d", state_dbg, S_F_MDR);
      else n_pass++;
      n_total++;
      if (cnt != 15) $display("FAIL tedge_mfa_cycles: got %0d want 15", cnt);
      else n_pass++;
      n_total++;
      if ({halted, err_code} !== 3'b000) $display("FAIL tedge_no_err: halted=%b err=%0d want 0,0", halted, err_code);
      else n_pass++;
      fetch_delay = 0;
   endtask

   task automatic test_reset_mid_store();
      int  st;
      bit  ok;
      dp_if.IR = 32'hC2206004;
      data_delay = -1;
      do_reset();
      wait_state(S_M_ST, 20, st, ok);
      @(negedge Clk);
      n_total++;
      if (!ok || state_dbg !== S_M_ST || dp_if.MFA !== 1'b1)
         $display("FAIL rst_mid_in_mst: found=%0d state=%0d MFA=%b want 1,%0d,1", ok, state_dbg, dp_if.MFA, S_M_ST);
      else n_pass++;
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_total++;
      if (state_dbg !== S_RST) $display("FAIL rst_mid_state: got %0d want %0d", state_dbg, S_RST);
      else n_pass++;
      n_total++;
      if (out_vec !== RESET_VEC) $display("FAIL rst_mid_outputs: got %h want %h", out_vec, RESET_VEC);
      else n_pass++;
      @(negedge Clk);
      n_total++;
      if (state_dbg !== S_F_MAR) $display("FAIL rst_mid_restart: got %0d want %0d", state_dbg, S_F_MAR);
      else n_pass++;
      data_delay = 0;
   endtask

   // ---------------- sequence ----------------
   initial begin
      Reset    = 1'b1;
      dp_if.IR = 32'h0;
      dp_if.N  = 1'b0;
      dp_if.Z  = 1'b0;
      test_reset();
      test_alu();
      test_alu_cc();
      test_load();
      test_store();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_timeout_edge();
      test_reset_mid_store();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
